pipe_hazard_unit: RTL
=====================

# pipe_hazard_unit

Parametrised hazard and forwarding unit for the pipelined CPU, sitting beside the ID stage. It replaces the fixed EXE/MEM destination comparison with an internal scoreboard that tracks destination tags for DEPTH downstream stages. From that scoreboard it produces operand forwarding selects, load-use stalls for any load latency, and branch-flush bubbles. Saturating stall and flush event counters feed performance monitoring.

## Interface
- RW, 5: register-number width; register 0 is hardwired zero and is never a hazard source.
- DEPTH, 3: number of tracked stages after ID. Stage 0 = EXE, 1 = MEM, 2 = WB, and so on. Minimum 2.
- LOAD_STAGE, 1: first stage index whose output holds load data. Must satisfy 1 ≤ LOAD_STAGE < DEPTH.
- CNT_W, 16: event counter width.
- FW (derived, not overridable): ceil(log2(DEPTH+1)), the forwarding-select width.

Ports:
- clk, in, 1: single clock, rising edge.
- clrn, in, 1: synchronous, active-high reset. 1 clears the block at the clock edge.
- id_valid, in, 1: ID holds a real instruction.
- id_rs, in, RW: source A register number.
- id_rt, in, RW: source B register number.
- id_use_rs, in, 1: instruction reads rs.
- id_use_rt, in, 1: instruction reads rt.
- id_wreg, in, 1: instruction writes a register.
- id_rn, in, RW: destination register number.
- id_m2reg, in, 1: instruction is a load.
- br_taken, in, 1: branch resolved taken this cycle. The instruction in ID is wrong-path.
- stall, out, 1: hold PC and IF/ID; inject a bubble into EXE.
- id_kill, out, 1: the ID instruction is squashed. Equals br_taken & id_valid.
- issue, out, 1: the ID instruction enters EXE at the next edge.
- fwd_a, out, FW: operand A source. 0 = register file; k = result of stage k-1.
- fwd_b, out, FW: operand B source, same encoding as fwd_a.
- stall_cnt, out, CNT_W: cycles with stall = 1, saturating.
- flush_cnt, out, CNT_W: cycles with id_kill = 1, saturating.

## Operation
- Scoreboard: entries sb[0..DEPTH-1], each holding {v, w, rn, ld}.
  - Each edge, sb[i] <= sb[i-1] for i ≥ 1.
  - sb[0] <= {1, id_wreg, id_rn, id_m2reg} when issue = 1; otherwise sb[0] <= a bubble (v = 0).
  - The scoreboard never freezes. Stalls insert bubbles; they do not hold older stages.
- Match rule for operand X (rs or rt):
  - X is hazard-eligible when use_X = 1, X ≠ 0 and id_valid = 1.
  - Find the smallest i with sb[i].v & sb[i].w & sb[i].rn == X. The youngest producer wins.
- Forward and stall decision for a match at stage i:
  - If sb[i].ld = 1 and i < LOAD_STAGE, the operand is not ready: raise a load-use hazard and set fwd_X = 0.
  - Otherwise fwd_X = i+1.
  - With no match, or when X is not eligible, fwd_X = 0.
- stall = (hazard_a | hazard_b) & ~br_taken.
- issue = id_valid & ~stall & ~br_taken.
- br_taken has priority over stall. The ID instruction is dropped, stall = 0, and a bubble enters sb[0].
- Counters: stall_cnt increments on each cycle with stall = 1. flush_cnt increments on each cycle with id_kill = 1. Both hold at 2^CNT_W - 1 once reached.

## Timing
- stall, issue, id_kill, fwd_a and fwd_b are combinational from the current ID inputs and registered scoreboard. There are no flops on these paths.
- Scoreboard and counters update on the rising clk edge.
- Load-use stall length is LOAD_STAGE - i cycles for a load matched at stage i. With the defaults, a back-to-back load-use pair stalls exactly 1 cycle, then forwards with fwd = 2.
- Reset (clrn = 1 at an edge): all sb[].v = 0, stall_cnt = 0, flush_cnt = 0.
  - After reset, with any ID inputs: stall = 0, fwd_a = fwd_b = 0, issue = id_valid & ~br_taken.
- Reset asserted mid-stall: the scoreboard empties, so the stall releases on the next cycle. Reset overrides the counter increment on that same edge.
- Simultaneous br_taken and load-use hazard: stall = 0, id_kill = 1, flush_cnt increments, stall_cnt does not.
- id_rs == id_rt, both eligible: fwd_a = fwd_b, and a single hazard drives stall.
- Counter saturation: at the maximum value, further events leave the counter unchanged (no wrap).

## Test plan
All scenarios use defaults: RW = 5, DEPTH = 3, LOAD_STAGE = 1.
1. ALU-distance sweep.
   - Stimulus: add r3 issued, then consumers of r3 at distance 1, 2, 3 and 4.
   - Response: fwd_a = 1, 2, 3, 0 respectively; stall = 0 throughout.
2. Load-use.
   - Stimulus: lw r5, then immediately add r6,r5,r5.
   - Response: stall = 1 for one cycle, with a bubble in sb[0]. Next cycle: fwd_a = fwd_b = 2, issue = 1, stall_cnt = 1.
3. Youngest producer and r0.
   - Stimulus: two writes to r7 back-to-back, then a reader of r7. Separately, a write to r0 followed by a reader of r0.
   - Response: r7 reader gets fwd = 1. r0 reader gets fwd = 0.
4. Flush priority.
   - Stimulus: load-use hazard pending while br_taken = 1.
   - Response: stall = 0, id_kill = 1, issue = 0, flush_cnt increments by 1. Next cycle sb[0].v = 0.
5. Reset mid-stall.
   - Stimulus: clrn pulsed during a load-use stall.
   - Response: next cycle stall = 0, fwd = 0, both counters = 0.
6. Saturation.
   - Stimulus: run with CNT_W = 2 and hold stall for 5 cycles.
   - Response: stall_cnt reads 1, 2, 3, 3, 3.

Source files
------------

// File: rtl/pipe_hazard_unit.sv
// Hazard and forwarding unit beside the ID stage. A shifting scoreboard of
// downstream destination tags drives operand forwarding selects, load-use
// stalls and branch-flush bubbles, plus saturating stall/flush counters.

// Per-operand producer search: youngest matching scoreboard entry wins.
module phu_operand_match #(
    parameter int RW         = 5,
    parameter int DEPTH      = 3,
    parameter int LOAD_STAGE = 1,
    parameter int FW         = 2
) (
    input  logic                       eligible,
    input  logic [RW-1:0]              src,
    input  logic [DEPTH-1:0]           sb_v,
    input  logic [DEPTH-1:0]           sb_w,
    input  logic [DEPTH-1:0]           sb_ld,
    input  logic [DEPTH-1:0][RW-1:0]   sb_rn,
    output logic [FW-1:0]              fwd,
    output logic                       hazard
);

    // Scan oldest to youngest so the youngest match overwrites older ones.
    always_comb begin
        fwd    = '0;
        hazard = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (eligible && sb_v[i] && sb_w[i] && (sb_rn[i] == src)) begin
                if (sb_ld[i] && (i < LOAD_STAGE)) begin
                    // Load data not produced yet: no forward, stall instead.
                    hazard = 1'b1;
                    fwd    = '0;
                end else begin
                    hazard = 1'b0;
                    fwd    = FW'(i + 1);
                end
            end
        end
    end

endmodule

module pipe_hazard_unit #(
    parameter int  RW         = 5,
    parameter int  DEPTH      = 3,
    parameter int  LOAD_STAGE = 1,
    parameter int  CNT_W      = 16,
    localparam int FW         = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             id_valid,
    input  logic [RW-1:0]    id_rs,
    input  logic [RW-1:0]    id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_wreg,
    input  logic [RW-1:0]    id_rn,
    input  logic             id_m2reg,
    input  logic             br_taken,
    output logic             stall,
    output logic             id_kill,
    output logic             issue,
    output logic [FW-1:0]    fwd_a,
    output logic [FW-1:0]    fwd_b,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    // Scoreboard, stage 0 = EXE. Fields are split into packed vectors so the
    // per-stage shift is a single concatenation.
    logic [DEPTH-1:0]         sb_v;
    logic [DEPTH-1:0]         sb_w;
    logic [DEPTH-1:0]         sb_ld;
    logic [DEPTH-1:0][RW-1:0] sb_rn;

    logic [1:0]               elig;
    logic [1:0][RW-1:0]       src;
    logic [1:0][FW-1:0]       fwd;
    logic [1:0]               hazard;

    // Operand 0 = rs (A), operand 1 = rt (B); register 0 never matches.
    always_comb begin
        src[0]  = id_rs;
        src[1]  = id_rt;
        elig[0] = id_valid & id_use_rs & (id_rs != '0);
        elig[1] = id_valid & id_use_rt & (id_rt != '0);
    end

    for (genvar g = 0; g < 2; g++) begin : g_op
        phu_operand_match #(
            .RW         (RW),
            .DEPTH      (DEPTH),
            .LOAD_STAGE (LOAD_STAGE),
            .FW         (FW)
        ) u_match (
            .eligible (elig[g]),
            .src      (src[g]),
            .sb_v     (sb_v),
            .sb_w     (sb_w),
            .sb_ld    (sb_ld),
            .sb_rn    (sb_rn),
            .fwd      (fwd[g]),
            .hazard   (hazard[g])
        );
    end

    // Branch flush outranks the load-use stall; both are purely combinational.
    always_comb begin
        fwd_a   = fwd[0];
        fwd_b   = fwd[1];
        stall   = (hazard[0] | hazard[1]) & ~br_taken;
        id_kill = br_taken & id_valid;
        issue   = id_valid & ~stall & ~br_taken;
    end

    // Scoreboard always advances; stalls and flushes enter as bubbles.
    always_ff @(posedge clk) begin
        if (clrn) begin
            sb_v  <= '0;
            sb_w  <= '0;
            sb_ld <= '0;
            sb_rn <= '0;
        end else begin
            sb_v  <= {sb_v[DEPTH-2:0], issue};
            sb_w  <= {sb_w[DEPTH-2:0], id_wreg};
            sb_ld <= {sb_ld[DEPTH-2:0], id_m2reg};
            sb_rn <= {sb_rn[DEPTH-2:0], id_rn};
        end
    end

    // Saturating event counters; reset wins over a same-edge increment.
    always_ff @(posedge clk) begin
        if (clrn) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;
            if (id_kill && (flush_cnt != '1))
                flush_cnt <= flush_cnt + 1'b1;
        end
    end

endmodule
